// File: rtl/sreg_marshaller_pkg.sv
// Shared constants, word type and width helper for the serial-to-parallel marshaller.
package sreg_marshaller_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] word_t;

  // Width of a counter that indexes bits within a word; never narrower than 1.
  function automatic int cnt_w(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/sreg_marshaller_if.sv
// Serial input and assembled-word outputs of the marshaller, bundled for port hookup.
interface sreg_marshaller_if #(
  parameter int DATA_W = sreg_marshaller_pkg::DATA_W_DEF,
  parameter int CNT_W  = sreg_marshaller_pkg::CNT_W_DEF,
  parameter int BC_W   = sreg_marshaller_pkg::cnt_w(DATA_W)
);
  logic              serial_in;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  word_count;

  // master feeds the stream; slave is the marshaller.
  modport master (
    output serial_in,
    input  byte_out, byte_valid, bit_cnt, word_count
  );

  modport slave (
    input  serial_in,
    output byte_out, byte_valid, bit_cnt, word_count
  );
endinterface

// File: rtl/sreg_marshaller_sipo.sv
// Shift register plus bit counter; presents the word that the current edge would complete.
module sipo_shift_reg
  import sreg_marshaller_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit LSB_FIRST = 1'b1,
  parameter int BC_W      = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] word,
  output logic              complete,
  output logic [BC_W-1:0]   bit_cnt
);

  // Only DATA_W-1 bits need storing: the last bit of a word comes straight
  // from serial_in on the completing edge, and the oldest bit falls off.
  logic [DATA_W-2:0] sr;
  logic [DATA_W-1:0] word_nxt;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign word_nxt = {serial_in, sr};
    end else begin : g_msb
      assign word_nxt = {sr, serial_in};
    end
  endgenerate

  assign word     = word_nxt;
  assign complete = (bit_cnt == BC_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (LSB_FIRST) sr <= word_nxt[DATA_W-1:1];
      else           sr <= word_nxt[DATA_W-2:0];
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sreg_marshaller.sv
// Serial-to-parallel marshaller: held word output, one-cycle valid strobe, word counter.
module sreg_marshaller
  import sreg_marshaller_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sreg_marshaller_if.slave  bus
);

  localparam int BC_W = cnt_w(DATA_W);

  logic [DATA_W-1:0] word_nxt;
  logic              complete;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] byte_q;
  logic              valid_q;
  logic [CNT_W-1:0]  wcnt_q;

  sipo_shift_reg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST),
    .BC_W      (BC_W)
  ) u_sipo (
    .clk       (clk),
    .rst       (rst),
    .serial_in (bus.serial_in),
    .word      (word_nxt),
    .complete  (complete),
    .bit_cnt   (bit_cnt)
  );

  // Load on the completing edge itself so the word appears with zero added latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q  <= '0;
      valid_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      valid_q <= complete;
      if (complete) begin
        byte_q <= word_nxt;
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.bit_cnt    = bit_cnt;
  assign bus.word_count = wcnt_q;

endmodule

// File: tb/tb_sreg_marshaller.sv
// Directed bench: default build plus MSB-first, 4-bit and 2-bit-counter variants.
module tb_sreg_marshaller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  sreg_marshaller_if #(.DATA_W(8), .CNT_W(16)) if_m   ();
  sreg_marshaller_if #(.DATA_W(8), .CNT_W(16)) if_msb ();
  sreg_marshaller_if #(.DATA_W(4), .CNT_W(16)) if_w4  ();
  sreg_marshaller_if #(.DATA_W(8), .CNT_W(2))  if_c2  ();

  sreg_marshaller #(.DATA_W(8), .LSB_FIRST(1'b1), .CNT_W(16)) u_m   (.clk(clk), .rst(rst), .bus(if_m));
  sreg_marshaller #(.DATA_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) u_msb (.clk(clk), .rst(rst), .bus(if_msb));
  sreg_marshaller #(.DATA_W(4), .LSB_FIRST(1'b1), .CNT_W(16)) u_w4  (.clk(clk), .rst(rst), .bus(if_w4));
  sreg_marshaller #(.DATA_W(8), .LSB_FIRST(1'b1), .CNT_W(2))  u_c2  (.clk(clk), .rst(rst), .bus(if_c2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-period reset pulse; outputs are checked while rst is still low.
  task automatic async_rst_pulse(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_byte"},  32'(if_m.byte_out),   32'h0);
    chk({tag, "_valid"}, 32'(if_m.byte_valid), 32'h0);
    chk({tag, "_bcnt"},  32'(if_m.bit_cnt),    32'h0);
    chk({tag, "_wcnt"},  32'(if_m.word_count), 32'h0);
    #1 rst = 1'b1;
  endtask

  logic [7:0] exp_bytes [4] = '{8'h34, 8'h12, 8'hCD, 8'hAB};
  logic [31:0] stream = 32'hABCD1234;
  logic [7:0]  b34 = 8'h34;
  logic [7:0]  b5a = 8'h5A;
  logic        msb_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        w4_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0]  c2_wc   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0]  exp_b;
  int          c2_pulses;

  initial begin
    if_m.serial_in = 1'b0; if_msb.serial_in = 1'b0;
    if_w4.serial_in = 1'b0; if_c2.serial_in = 1'b0;

    // Reset held for two cycles
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_byte",  32'(if_m.byte_out),   32'h0);
    chk("rst_valid", 32'(if_m.byte_valid), 32'h0);
    chk("rst_bcnt",  32'(if_m.bit_cnt),    32'h0);
    chk("rst_wcnt",  32'(if_m.word_count), 32'h0);
    rst = 1'b1;

    // 0xABCD1234 LSB-first
    exp_b = 8'h00;
    for (int k = 1; k <= 32; k++) begin
      if_m.serial_in = stream[k-1];
      tick();
      if (k % 8 == 0) exp_b = exp_bytes[k/8-1];
      chk($sformatf("strm_valid_e%0d", k), 32'(if_m.byte_valid), 32'((k % 8) == 0));
      chk($sformatf("strm_bcnt_e%0d", k),  32'(if_m.bit_cnt),    32'(k % 8));
      chk($sformatf("strm_byte_e%0d", k),  32'(if_m.byte_out),   32'(exp_b));
    end
    chk("strm_wcnt", 32'(if_m.word_count), 32'd4);

    // Constant ones: hold 0xAB until edge 40 completes 0xFF
    for (int k = 33; k <= 44; k++) begin
      if_m.serial_in = 1'b1;
      tick();
      chk($sformatf("ones_valid_e%0d", k), 32'(if_m.byte_valid), 32'(k == 40));
      chk($sformatf("ones_byte_e%0d", k),  32'(if_m.byte_out),   (k >= 40) ? 32'hFF : 32'hAB);
    end
    chk("ones_wcnt", 32'(if_m.word_count), 32'd5);
    chk("ones_bcnt", 32'(if_m.bit_cnt),    32'd4);

    async_rst_pulse("arst");

    // Partial word of 0x34, reset, then 0x5A framed fresh
    for (int k = 0; k < 5; k++) begin
      if_m.serial_in = b34[k];
      tick();
    end
    chk("mid_bcnt5", 32'(if_m.bit_cnt),  32'd5);
    chk("mid_byte5", 32'(if_m.byte_out), 32'h0);
    async_rst_pulse("midrst");
    for (int k = 1; k <= 8; k++) begin
      if_m.serial_in = b5a[k-1];
      tick();
      chk($sformatf("mid_valid_e%0d", k), 32'(if_m.byte_valid), 32'(k == 8));
      chk($sformatf("mid_byte_e%0d", k),  32'(if_m.byte_out),   (k == 8) ? 32'h5A : 32'h0);
    end
    chk("mid_wcnt", 32'(if_m.word_count), 32'd1);

    // Parameter variants, all framed from one shared reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    c2_pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      if_msb.serial_in = (k <= 8) ? msb_seq[k-1] : 1'b0;
      if_w4.serial_in  = w4_seq[(k-1) % 4];
      if_c2.serial_in  = 1'((k-1) % 2);
      tick();
      if (if_c2.byte_valid) c2_pulses++;
      if (k == 3) chk("w4_valid_e3", 32'(if_w4.byte_valid), 32'd0);
      if (k == 4) begin
        chk("w4_valid_e4", 32'(if_w4.byte_valid), 32'd1);
        chk("w4_byte_e4",  32'(if_w4.byte_out),   32'hD);
      end
      if (k == 7) begin
        chk("msb_valid_e7", 32'(if_msb.byte_valid), 32'd0);
        chk("msb_byte_e7",  32'(if_msb.byte_out),   32'h0);
      end
      if (k == 8) begin
        chk("msb_valid_e8", 32'(if_msb.byte_valid), 32'd1);
        chk("msb_byte_e8",  32'(if_msb.byte_out),   32'hA5);
      end
      if (k % 8 == 0) begin
        chk($sformatf("c2_wcnt_w%0d", k/8), 32'(if_c2.word_count), 32'(c2_wc[k/8-1]));
        chk($sformatf("c2_byte_w%0d", k/8), 32'(if_c2.byte_out),   32'hAA);
      end
    end
    chk("c2_pulses", 32'(c2_pulses), 32'd5);
    chk("w4_wcnt",   32'(if_w4.word_count), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
